cofi_multi: RTL
===============

# cofi_multi

Parametrised horizontal blending filter: the successor to the two-tap composite-style blender. It selects one of four kernels (bypass, 2-tap average, 3-tap 1-2-1, 3:1 weighted) with rounded full-precision arithmetic and one-pixel lookahead, so both edges of the active line are handled. Sync and blank signals are delayed to match the filter. It sits between the core's video output and the scandoubler/OSD path and runs in the pixel clock domain, gated by `pix_ce`.

## Interface
- VIDEO_DEPTH, 8: bits per colour channel.
- BLANK_ZERO, 1: 1 forces colour outputs to 0 while `hblank_out|vblank_out`; 0 passes the filtered value through.

- clk  in  1  video clock.
- reset  in  1  synchronous, active-high.
- pix_ce  in  1  pixel clock enable; all state advances only when high.
- mode  in  2  kernel request: 0 bypass, 1 2-tap avg, 2 3-tap 1-2-1, 3 3:1 weighted.
- hblank, vblank, hs, vs  in  1 each  input timing.
- red, green, blue  in  VIDEO_DEPTH each  input pixel.
- hblank_out, vblank_out, hs_out, vs_out  out  1 each  delayed timing.
- red_out, green_out, blue_out  out  VIDEO_DEPTH each  filtered pixel.

## Operation
- History: `cur` holds the pixel from the previous ce, and `prv` holds the one before it. Each has its own hblank flag. The current input acts as `nxt` (lookahead).
- On each ce: `prv<=cur`, `cur<=input`. Outputs are computed from (prv, cur, nxt=input) and registered in the same ce.
- Edge substitution, applied per channel:
  - If `prv` hblank flag is 1, P=C.
  - If the input hblank is 1, N=C.
  - If `cur` is itself blank, the output is C unfiltered.
- Kernels, with intermediates VIDEO_DEPTH+2 bits wide and no overflow:
  - mode 0: C.
  - mode 1: (P+C+1)>>1.
  - mode 2: (P+2C+N+2)>>2.
  - mode 3: (P+3C+2)>>2.
  - Results never exceed 2^VIDEO_DEPTH-1.
- Mode latching: `mode_act` loads `mode` only on a ce where vblank=1 and the registered previous vblank=0 (rising edge). A mode change mid-frame therefore takes effect at the next frame. After reset, `mode_act=0` until the first vblank rising edge.
- Timing signals: the hblank, vblank, hs and vs values stored alongside `cur` are registered to the *_out ports on the same ce as the colours, so they stay aligned.
- Blanking: if BLANK_ZERO=1 and the delayed hblank or vblank is 1, colour outputs are 0.

## Timing
- Latency: the pixel sampled at ce event k appears on the outputs after ce event k+1, in every mode including bypass. Latency is constant, so there is no sync shift on mode change.
- Without `pix_ce`, all registers hold their values. The ce spacing is arbitrary (1..n clk).
- Reset, applied on any clk edge regardless of pix_ce:
  - All outputs become 0.
  - prv/cur are cleared, and their blank flags are set to 1 so the first pixels act as edges.
  - `mode_act=0` and the previous-vblank register is 0.
- Reset mid-line: the first post-reset active pixel is treated as a left edge.
- Simultaneous mode change and vblank edge: the value of `mode` sampled on that ce is latched.
- Single-pixel active region: P=N=C, so every kernel outputs C.

## Test plan
- **Reset.** Assert reset for 3 clk with random inputs. Required: every output is 0, and the first frame after reset is bypass even with mode=2.
- **Mode 1.** After a vblank edge, drive active pixels red 10, 20, 255, 0. Required: red_out is 10 (left edge), 15, 138, 128, delayed by one ce.
- **Mode 2 edges.** Drive the line 100, 0, 100, then hblank. Required: 75 (left edge, N=0), 50, 75 (right edge). Check 255, 255, 255 gives 255 with no overflow.
- **Mode 3.** Drive 0 followed by 200. Required: 0, then 150.
- **Mid-frame mode change.** Switch mode 1→0 mid-line. Required: mode 1 filtering holds until the next vblank rising edge, and bypass starts from the first line after it. hs_out/vs_out edges land exactly one ce after the input edges in both modes.
- **pix_ce gating.** Use pix_ce at 1-in-4 with BLANK_ZERO=1. Required: outputs change only on ce cycles, and colours are 0 throughout hblank and vblank.

Source files
------------

// File: rtl/cofi_multi.sv
// cofi_multi: selectable horizontal blending filter (bypass, 2-tap, 1-2-1, 3:1) with one-pixel lookahead.
module cofi_multi #(
  parameter int VIDEO_DEPTH = 8,
  parameter bit BLANK_ZERO  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_ce,
  input  logic [1:0]             mode,
  input  logic                   hblank,
  input  logic                   vblank,
  input  logic                   hs,
  input  logic                   vs,
  input  logic [VIDEO_DEPTH-1:0] red,
  input  logic [VIDEO_DEPTH-1:0] green,
  input  logic [VIDEO_DEPTH-1:0] blue,
  output logic                   hblank_out,
  output logic                   vblank_out,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic [VIDEO_DEPTH-1:0] red_out,
  output logic [VIDEO_DEPTH-1:0] green_out,
  output logic [VIDEO_DEPTH-1:0] blue_out
);
  localparam int W = VIDEO_DEPTH + 2;
  logic [VIDEO_DEPTH-1:0] in_px  [3];
  logic [VIDEO_DEPTH-1:0] out_px [3];
  logic       prv_hb, cur_hb, cur_vb, cur_hs, cur_vs, blank_z;
  logic [1:0] mode_act;
  assign in_px[0]  = red;
  assign in_px[1]  = green;
  assign in_px[2]  = blue;
  assign red_out   = out_px[0];
  assign green_out = out_px[1];
  assign blue_out  = out_px[2];
  assign blank_z   = BLANK_ZERO && (cur_hb || cur_vb);
  // cur_vb doubles as the previous-vblank register for mode latching
  always_ff @(posedge clk) begin
    if (reset) begin
      prv_hb     <= 1'b1;
      cur_hb     <= 1'b1;
      cur_vb     <= 1'b0;
      cur_hs     <= 1'b0;
      cur_vs     <= 1'b0;
      mode_act   <= 2'd0;
      hblank_out <= 1'b0;
      vblank_out <= 1'b0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
    end else if (pix_ce) begin
      prv_hb     <= cur_hb;
      cur_hb     <= hblank;
      cur_vb     <= vblank;
      cur_hs     <= hs;
      cur_vs     <= vs;
      mode_act   <= (vblank && !cur_vb) ? mode : mode_act;
      hblank_out <= cur_hb;
      vblank_out <= cur_vb;
      hs_out     <= cur_hs;
      vs_out     <= cur_vs;
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [VIDEO_DEPTH-1:0] prv_px, cur_px, o;
    logic [W-1:0]           p, c, n, s;
    always_comb begin
      c = W'(cur_px);
      p = prv_hb ? c : W'(prv_px);
      n = hblank ? c : W'(in_px[i]);
      s = mode_act == 2'd1 ? (p + c + W'(1)) >> 1 :
          mode_act == 2'd2 ? (p + (c << 1) + n + W'(2)) >> 2 :
          mode_act == 2'd3 ? (p + (c << 1) + c + W'(2)) >> 2 : c;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        prv_px <= '0;
        cur_px <= '0;
        o      <= '0;
      end else if (pix_ce) begin
        prv_px <= cur_px;
        cur_px <= in_px[i];
        o      <= blank_z ? '0 : cur_hb ? cur_px :
                  |s[W-1:VIDEO_DEPTH] ? '1 : s[VIDEO_DEPTH-1:0];
      end
    end
    assign out_px[i] = o;
  end
endmodule
